// File: rtl/key_debounce.sv
// key_debounce: turns raw, bouncing, active-low push-button lines into clean
// per-key levels (state_o) and one-cycle press/release strobes (down_o/up_o).
//
// Each key has a 2-flop synchronizer followed by its own four-state FSM:
// RELEASED -> PRESS_CHK -> PRESSED -> RELEASE_CHK -> RELEASED.
// The FSM state of key k is visible as g_key[k].state for checkers.
//
// Optional feature, selected by the macro KEY_DEBOUNCE_AUTOREPEAT_EN:
// while a key stays PRESSED, down_o re-pulses REPEAT_DELAY cycles after the
// initial press and then every REPEAT_PERIOD cycles. Without the macro the
// repeat counters and the REPEAT_* parameters do not exist.
//
// Handshake: down_o and up_o are single-cycle strobes with no back-pressure.
// A consumer must sample them on the cycle they are high. state_o is a level.
module key_debounce #(
  parameter int N_KEYS          = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000,
`endif
  parameter int CNT_W           = 20
) (
  input  logic              clk100_i,
  input  logic              rstn_i,
  input  logic [N_KEYS-1:0] key_i,
  output logic [N_KEYS-1:0] state_o,
  output logic [N_KEYS-1:0] down_o,
  output logic [N_KEYS-1:0] up_o
);

  // Entering a check state already consumes one stable cycle, so the check
  // completes when cnt reaches DEBOUNCE_CYCLES-2. That gives exactly
  // DEBOUNCE_CYCLES check edges and cnt never gets near wrapping.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] RD_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RP_LAST = RPT_W'(REPEAT_PERIOD - 1);
`endif

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } key_state_t;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic             sync1;
    logic             sync2;
    logic             s;
    key_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             down_q;
    logic             up_q;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    logic [RPT_W-1:0] rcnt;
    logic             rphase;   // 0: waiting for first repeat, 1: periodic
`endif

    // Two-flop synchronizer; resets to the released (high) pin level.
    always_ff @(posedge clk100_i or negedge rstn_i) begin
      if (!rstn_i) begin
        sync1 <= 1'b1;
        sync2 <= 1'b1;
      end else begin
        sync1 <= key_i[k];
        sync2 <= sync1;
      end
    end

    // Active-high pressed indication seen by the FSM.
    assign s = ~sync2;

    // Debounce FSM with registered level and strobe outputs.
    always_ff @(posedge clk100_i or negedge rstn_i) begin
      if (!rstn_i) begin
        state   <= RELEASED;
        cnt     <= '0;
        level_q <= 1'b0;
        down_q  <= 1'b0;
        up_q    <= 1'b0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
        rcnt    <= '0;
        rphase  <= 1'b0;
`endif
      end else begin
        down_q <= 1'b0;
        up_q   <= 1'b0;
        case (state)
          RELEASED: begin
            if (s) begin
              state <= PRESS_CHK;
              cnt   <= '0;
            end
          end
          PRESS_CHK: begin
            if (!s) begin
              state <= RELEASED;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state   <= PRESSED;
              cnt     <= '0;
              level_q <= 1'b1;
              down_q  <= 1'b1;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
              rcnt    <= '0;
              rphase  <= 1'b0;
`endif
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          PRESSED: begin
            if (!s) begin
              state <= RELEASE_CHK;
              cnt   <= '0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
              rcnt   <= '0;
              rphase <= 1'b0;
`endif
            end
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            else if (rcnt == (rphase ? RP_LAST : RD_LAST)) begin
              down_q <= 1'b1;
              rcnt   <= '0;
              rphase <= 1'b1;
            end else begin
              rcnt <= rcnt + RPT_W'(1);
            end
`endif
          end
          RELEASE_CHK: begin
            if (s) begin
              state <= PRESSED;
              cnt   <= '0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
              rcnt   <= '0;
              rphase <= 1'b0;
`endif
            end else if (cnt == CNT_LAST) begin
              state   <= RELEASED;
              cnt     <= '0;
              level_q <= 1'b0;
              up_q    <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= RELEASED;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign state_o[k] = level_q;
    assign down_o[k]  = down_q;
    assign up_o[k]    = up_q;
  end

endmodule
